// File: rtl/anton_neopixel_frame_sequencer_pkg.sv
// rtl/anton_neopixel_frame_sequencer_pkg.sv - shared state encoding and default widths for the frame sequencer
package anton_neopixel_frame_sequencer_pkg;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_INIT = 2'd1,
      SEQ_RUN  = 2'd2,
      SEQ_GAP  = 2'd3
   } seq_state_t;

   localparam int GAP_BITS_DEFAULT   = 16;
   localparam int COUNT_BITS_DEFAULT = 16;

endpackage

// File: rtl/anton_neopixel_frame_sequencer_if.sv
// rtl/anton_neopixel_frame_sequencer_if.sv - control/status link between the frame sequencer and the stream logic
interface anton_neopixel_frame_sequencer_if;

   logic regCtrlInit;
   logic regCtrlRun;
   logic initSlow;
   logic initSlowDone;
   logic streamPixelOf;
   logic streamSyncOf;

   // sequencer side: drives the stream controls, watches its flags
   modport master (
      output regCtrlInit,
      output regCtrlRun,
      output initSlow,
      input  initSlowDone,
      input  streamPixelOf,
      input  streamSyncOf
   );

   // stream logic side
   modport slave (
      input  regCtrlInit,
      input  regCtrlRun,
      input  initSlow,
      output initSlowDone,
      output streamPixelOf,
      output streamSyncOf
   );

endinterface

// File: rtl/anton_neopixel_gap_timer.sv
// rtl/anton_neopixel_gap_timer.sv - loadable down-counter with zero flag for the inter-frame gap
module anton_neopixel_gap_timer
   import anton_neopixel_frame_sequencer_pkg::*;
#(
   parameter int WIDTH = GAP_BITS_DEFAULT
) (
   input  logic             clk6_4mhz,
   input  logic             rstn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             zero
);

   // load wins over decrement; the counter parks at zero
   always_ff @(posedge clk6_4mhz or negedge rstn) begin
      if (!rstn) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/anton_neopixel_frame_sequencer.sv
// rtl/anton_neopixel_frame_sequencer.sv - frame FSM, pending flags and frame counter driving the neopixel stream
module anton_neopixel_frame_sequencer
   import anton_neopixel_frame_sequencer_pkg::*;
#(
   parameter int GAP_BITS   = GAP_BITS_DEFAULT,
   parameter int COUNT_BITS = COUNT_BITS_DEFAULT
) (
   input  logic                  clk6_4mhz,
   input  logic                  rstn,
   input  logic                  cmdStart,
   input  logic                  cmdStop,
   input  logic                  cmdInit,
   input  logic                  cfgLoop,
   input  logic [GAP_BITS-1:0]   cfgGap,
   anton_neopixel_frame_sequencer_if.master stream,
   output logic                  busy,
   output logic                  frameDone,
   output logic [COUNT_BITS-1:0] frameCount,
   output logic                  stopPending
);

   seq_state_t state, state_n;
   logic startPending, start_pending_n;
   logic stop_pending_n;
   logic frame_end;
   logic gap_load, gap_dec, gap_zero;
   logic [GAP_BITS-1:0] gap_cnt;
   logic ctrl_init_q, ctrl_run_q, init_slow_q;
   logic pixel_err;

   anton_neopixel_gap_timer #(.WIDTH(GAP_BITS)) u_gap_timer (
      .clk6_4mhz  (clk6_4mhz),
      .rstn       (rstn),
      .load       (gap_load),
      .load_value (cfgGap - 1'b1),
      .dec        (gap_dec),
      .count      (gap_cnt),
      .zero       (gap_zero)
   );

   // next-state logic; stop beats start beats init, only stop is honoured outside IDLE
   always_comb begin
      state_n         = state;
      start_pending_n = startPending;
      stop_pending_n  = stopPending;
      frame_end       = 1'b0;
      gap_load        = 1'b0;
      gap_dec         = 1'b0;
      case (state)
         SEQ_IDLE: begin
            if (cmdStop) begin
               state_n = SEQ_IDLE;
            end else if (cmdStart) begin
               state_n         = SEQ_INIT;
               start_pending_n = 1'b1;
            end else if (cmdInit) begin
               state_n         = SEQ_INIT;
               start_pending_n = 1'b0;
            end
         end
         SEQ_INIT: begin
            if (cmdStop) begin
               start_pending_n = 1'b0;
            end
            if (stream.initSlowDone) begin
               state_n         = (startPending && !cmdStop) ? SEQ_RUN : SEQ_IDLE;
               start_pending_n = 1'b0;
            end
         end
         SEQ_RUN: begin
            if (cmdStop) begin
               stop_pending_n = 1'b1;
            end
            if (stream.streamSyncOf) begin
               frame_end = 1'b1;
               if (stopPending || cmdStop || !cfgLoop) begin
                  state_n        = SEQ_IDLE;
                  stop_pending_n = 1'b0;
               end else if (cfgGap != '0) begin
                  state_n  = SEQ_GAP;
                  gap_load = 1'b1;
               end
            end
         end
         SEQ_GAP: begin
            if (cmdStop) begin
               state_n = SEQ_IDLE;
            end else if (gap_zero) begin
               state_n = SEQ_RUN;
            end else begin
               gap_dec = 1'b1;
            end
         end
         default: state_n = SEQ_IDLE;
      endcase
   end

   // state, pending flags and registered outputs decoded from the next state
   always_ff @(posedge clk6_4mhz or negedge rstn) begin
      if (!rstn) begin
         state        <= SEQ_IDLE;
         startPending <= 1'b0;
         stopPending  <= 1'b0;
         ctrl_init_q  <= 1'b0;
         ctrl_run_q   <= 1'b0;
         init_slow_q  <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_n;
         startPending <= start_pending_n;
         stopPending  <= stop_pending_n;
         ctrl_init_q  <= (state_n == SEQ_INIT);
         ctrl_run_q   <= (state_n == SEQ_RUN);
         init_slow_q  <= (state_n == SEQ_INIT);
         busy         <= (state_n != SEQ_IDLE);
      end
   end

   // frame-done pulse and wrapping completed-frame counter
   always_ff @(posedge clk6_4mhz or negedge rstn) begin
      if (!rstn) begin
         frameDone  <= 1'b0;
         frameCount <= '0;
      end else begin
         frameDone <= frame_end;
         if (frame_end) begin
            frameCount <= frameCount + 1'b1;
         end
      end
   end

   // sticky flag: the stream claims a last pixel while we are not running it
   always_ff @(posedge clk6_4mhz or negedge rstn) begin
      if (!rstn) begin
         pixel_err <= 1'b0;
      end else if (stream.streamPixelOf && (state != SEQ_RUN)) begin
         pixel_err <= 1'b1;
      end
   end

   assert property (@(posedge clk6_4mhz) disable iff (!rstn) !pixel_err);

   assign stream.regCtrlInit = ctrl_init_q;
   assign stream.regCtrlRun  = ctrl_run_q;
   assign stream.initSlow    = init_slow_q;

endmodule

// File: tb/tb_anton_neopixel_frame_sequencer.sv
// tb/tb_anton_neopixel_frame_sequencer.sv - scoreboard bench for the neopixel frame sequencer
module tb_anton_neopixel_frame_sequencer;

   logic        clk6_4mhz;
   logic        rstn;
   logic        cmdStart, cmdStop, cmdInit, cfgLoop;
   logic [15:0] cfgGap;
   logic        busy, frameDone, stopPending;
   logic [15:0] frameCount;

   anton_neopixel_frame_sequencer_if sif ();

   anton_neopixel_frame_sequencer dut (
      .clk6_4mhz   (clk6_4mhz),
      .rstn        (rstn),
      .cmdStart    (cmdStart),
      .cmdStop     (cmdStop),
      .cmdInit     (cmdInit),
      .cfgLoop     (cfgLoop),
      .cfgGap      (cfgGap),
      .stream      (sif),
      .busy        (busy),
      .frameDone   (frameDone),
      .frameCount  (frameCount),
      .stopPending (stopPending)
   );

   int          total;
   int          passes;
   logic [15:0] exp_count;
   logic [15:0] exp_q [$];
   logic [15:0] mon_exp;
   logic        watch;
   int          run_low_cnt, run_high_cnt;

   initial clk6_4mhz = 1'b0;
   always #5 clk6_4mhz = ~clk6_4mhz;

   // scoreboard: every frameDone pulse must match the next expected count
   always @(negedge clk6_4mhz) begin
      if (rstn && frameDone) begin
         total++;
         if (exp_q.size() == 0) begin
            $display("FAIL frame_done_unexpected: frameCount=%0d, required no frameDone", frameCount);
         end else begin
            mon_exp = exp_q.pop_front();
            if (frameCount !== mon_exp)
               $display("FAIL frame_count_sb: got %0d, expected %0d", frameCount, mon_exp);
            else
               passes++;
         end
      end
      if (watch) begin
         if (sif.regCtrlRun === 1'b0) run_low_cnt++;
         if (sif.regCtrlRun === 1'b1) run_high_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk6_4mhz);
      #1;
   endtask

   task automatic apply_reset();
      cmdStart = 0; cmdStop = 0; cmdInit = 0;
      sif.initSlowDone = 0; sif.streamPixelOf = 0; sif.streamSyncOf = 0;
      rstn = 0;
      tick(); tick();
      exp_q.delete();
      exp_count = 0;
      rstn = 1;
      tick();
   endtask

   task automatic start_to_run();
      cmdStart = 1; tick(); cmdStart = 0;
      tick();
      sif.initSlowDone = 1; tick(); sif.initSlowDone = 0;
   endtask

   task automatic run_frame(input int len);
      repeat (len) tick();
      sif.streamPixelOf = 1; tick(); sif.streamPixelOf = 0;
      sif.streamSyncOf = 1;
      exp_count = exp_count + 1'b1;
      exp_q.push_back(exp_count);
      tick();
      sif.streamSyncOf = 0;
   endtask

   task automatic test_reset();
      apply_reset();
      total++;
      if ({sif.regCtrlInit, sif.regCtrlRun, sif.initSlow, busy, frameDone, stopPending} !== 6'b0)
         $display("FAIL reset_outputs: got %b, expected 000000",
                  {sif.regCtrlInit, sif.regCtrlRun, sif.initSlow, busy, frameDone, stopPending});
      else passes++;
      total++;
      if (frameCount !== 16'd0) $display("FAIL reset_count: got %0d, expected 0", frameCount);
      else passes++;
   endtask

   task automatic test_one_shot();
      apply_reset();
      cfgLoop = 0; cfgGap = 16'd3;
      cmdStart = 1; tick(); cmdStart = 0;
      total++;
      if ({sif.initSlow, sif.regCtrlInit, sif.regCtrlRun, busy} !== 4'b1101)
         $display("FAIL one_shot_init: got %b, expected 1101", {sif.initSlow, sif.regCtrlInit, sif.regCtrlRun, busy});
      else passes++;
      tick();
      sif.initSlowDone = 1; tick(); sif.initSlowDone = 0;
      total++;
      if ({sif.regCtrlRun, sif.initSlow} !== 2'b10)
         $display("FAIL one_shot_run: got %b, expected 10", {sif.regCtrlRun, sif.initSlow});
      else passes++;
      run_frame(4);
      total++;
      if ({frameDone, sif.regCtrlRun, busy} !== 3'b100)
         $display("FAIL one_shot_end: got %b, expected 100", {frameDone, sif.regCtrlRun, busy});
      else passes++;
      total++;
      if (frameCount !== 16'd1) $display("FAIL one_shot_count: got %0d, expected 1", frameCount);
      else passes++;
      tick();
      total++;
      if (frameDone !== 1'b0) $display("FAIL one_shot_pulse: got %b, expected 0", frameDone);
      else passes++;
   endtask

   task automatic test_loop_gap();
      int low;
      apply_reset();
      cfgLoop = 1; cfgGap = 16'd5;
      start_to_run();
      for (int f = 0; f < 3; f++) begin
         run_frame(3);
         if (f == 0) cfgGap = 16'd9;
         low = 0;
         while (sif.regCtrlRun === 1'b0 && low < 20) begin
            low++;
            tick();
         end
         cfgGap = 16'd5;
         total++;
         if (low !== 5) $display("FAIL gap_window_%0d: got %0d cycles, expected 5", f, low);
         else passes++;
      end
      tick(); tick();
      cmdStop = 1; tick(); cmdStop = 0;
      total++;
      if ({stopPending, sif.regCtrlRun} !== 2'b11)
         $display("FAIL stop_pending_set: got %b, expected 11", {stopPending, sif.regCtrlRun});
      else passes++;
      run_frame(2);
      total++;
      if ({sif.regCtrlRun, busy, stopPending} !== 3'b000)
         $display("FAIL loop_stop_end: got %b, expected 000", {sif.regCtrlRun, busy, stopPending});
      else passes++;
      total++;
      if (frameCount !== 16'd4) $display("FAIL loop_stop_count: got %0d, expected 4", frameCount);
      else passes++;
   endtask

   task automatic test_loop_no_gap();
      apply_reset();
      cfgLoop = 1; cfgGap = 16'd0;
      start_to_run();
      run_low_cnt = 0; watch = 1;
      for (int f = 0; f < 3; f++) begin
         run_frame(2);
         total++;
         if (frameCount !== exp_count)
            $display("FAIL no_gap_count_%0d: got %0d, expected %0d", f, frameCount, exp_count);
         else passes++;
      end
      watch = 0;
      total++;
      if (run_low_cnt !== 0) $display("FAIL no_gap_run_dips: got %0d low cycles, expected 0", run_low_cnt);
      else passes++;
      cmdStop = 1; tick(); cmdStop = 0;
      run_frame(1);
      total++;
      if (busy !== 1'b0) $display("FAIL no_gap_stop: busy got %b, expected 0", busy);
      else passes++;
   endtask

   task automatic test_stop_cases();
      apply_reset();
      cmdStart = 1; cmdStop = 1; tick(); cmdStart = 0; cmdStop = 0;
      total++;
      if ({busy, sif.initSlow} !== 2'b00)
         $display("FAIL start_stop_same: got %b, expected 00", {busy, sif.initSlow});
      else passes++;
      cfgLoop = 1; cfgGap = 16'd5;
      start_to_run();
      run_frame(2);
      tick();
      total++;
      if ({sif.regCtrlRun, busy} !== 2'b01)
         $display("FAIL in_gap: got %b, expected 01", {sif.regCtrlRun, busy});
      else passes++;
      cmdStop = 1; tick(); cmdStop = 0;
      total++;
      if (busy !== 1'b0) $display("FAIL gap_stop_idle: busy got %b, expected 0", busy);
      else passes++;
      run_high_cnt = 0; watch = 1;
      repeat (8) tick();
      watch = 0;
      total++;
      if (run_high_cnt !== 0) $display("FAIL gap_stop_resume: got %0d run cycles, expected 0", run_high_cnt);
      else passes++;
   endtask

   task automatic test_init_only();
      apply_reset();
      cmdInit = 1; tick(); cmdInit = 0;
      run_high_cnt = 0; watch = 1;
      total++;
      if ({sif.initSlow, sif.regCtrlInit, busy} !== 3'b111)
         $display("FAIL init_only_enter: got %b, expected 111", {sif.initSlow, sif.regCtrlInit, busy});
      else passes++;
      repeat (4) tick();
      total++;
      if (sif.initSlow !== 1'b1) $display("FAIL init_only_hold: got %b, expected 1", sif.initSlow);
      else passes++;
      sif.initSlowDone = 1; tick(); sif.initSlowDone = 0;
      total++;
      if ({busy, sif.initSlow, sif.regCtrlInit} !== 3'b000)
         $display("FAIL init_only_done: got %b, expected 000", {busy, sif.initSlow, sif.regCtrlInit});
      else passes++;
      repeat (4) tick();
      watch = 0;
      total++;
      if (run_high_cnt !== 0) $display("FAIL init_only_run: got %0d run cycles, expected 0", run_high_cnt);
      else passes++;
   endtask

   task automatic test_async_reset();
      apply_reset();
      cfgLoop = 1; cfgGap = 16'd0;
      start_to_run();
      run_frame(2);
      tick(); tick();
      #2;
      rstn = 0;
      #1;
      total++;
      if ({sif.regCtrlRun, sif.regCtrlInit, sif.initSlow, busy, frameDone, stopPending} !== 6'b0)
         $display("FAIL async_reset_outputs: got %b, expected 000000",
                  {sif.regCtrlRun, sif.regCtrlInit, sif.initSlow, busy, frameDone, stopPending});
      else passes++;
      total++;
      if (frameCount !== 16'd0) $display("FAIL async_reset_count: got %0d, expected 0", frameCount);
      else passes++;
      exp_q.delete();
      exp_count = 0;
      tick();
      rstn = 1;
      tick();
   endtask

   task automatic test_wrap();
      apply_reset();
      cfgLoop = 1; cfgGap = 16'd0;
      start_to_run();
      for (int i = 0; i < 65535; i++) begin
         sif.streamSyncOf = 1;
         exp_count = exp_count + 1'b1;
         exp_q.push_back(exp_count);
         tick();
      end
      sif.streamSyncOf = 0;
      total++;
      if (frameCount !== 16'hFFFF) $display("FAIL wrap_full: got %h, expected ffff", frameCount);
      else passes++;
      sif.streamSyncOf = 1;
      exp_count = exp_count + 1'b1;
      exp_q.push_back(exp_count);
      tick();
      sif.streamSyncOf = 0;
      total++;
      if (frameCount !== 16'h0000) $display("FAIL wrap_zero: got %h, expected 0000", frameCount);
      else passes++;
      cmdStop = 1; tick(); cmdStop = 0;
      run_frame(1);
   endtask

   initial begin
      total = 0; passes = 0; watch = 0;
      run_low_cnt = 0; run_high_cnt = 0;
      exp_count = 0;
      cfgLoop = 0; cfgGap = 0;
      test_reset();
      test_one_shot();
      test_loop_gap();
      test_loop_no_gap();
      test_stop_cases();
      test_init_only();
      test_async_reset();
      test_wrap();
      tick();
      total++;
      if (exp_q.size() != 0) $display("FAIL sb_drain: got %0d pending frames, expected 0", exp_q.size());
      else passes++;
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
